prbs_mem_bist: RTL and testbench
================================

# prbs_mem_bist

Pseudo-random memory BIST engine that sits directly downstream of `LFSR_16B` in the memctrl BISR path. It consumes the free-running 16-bit LFSR output as write data, sweeps the target SRAM with a write pass and then a read pass, and compresses both streams into two 16-bit MISR signatures. It then reports pass/fail to the repair controller. Because only signatures are compared, the LFSR needs no enable or seed.

## Interface
Parameters:
- `ADDR_W`, default 6: SRAM address width; sweep depth is N = 2^ADDR_W words.
- `DATA_W`, default 16: data width; fixed to match the `LFSR_16B` output.

Ports:
- `clk`  in  1  single clock for the block.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a test; sampled only in IDLE.
- `lfsr_data`  in  16  `out` of `LFSR_16B`.
- `mem_req`  out  1  SRAM access strobe.
- `mem_we`  out  1  1 = write, 0 = read; valid when `mem_req`=1.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wdata`  out  16  write data, equal to `lfsr_data` in the same cycle.
- `mem_rdata`  in  16  SRAM read data, valid exactly 1 cycle after a read request.
- `busy`  out  1  high from the first WRITE cycle through CMP.
- `done`  out  1  one-cycle pulse when the result is final.
- `pass`  out  1  result level; held until the next accepted `start`.
- `sig_w`, `sig_r`  out  16 each  write and read signatures, for debug and for the bench.

## Operation
- States: IDLE → WRITE → READ → DRAIN → CMP → DONE → IDLE.
- IDLE: `start`=1 clears both MISRs and the address counter to 0, clears `pass`, and moves to WRITE.
- WRITE: `mem_req`=1, `mem_we`=1, `mem_wdata`=`lfsr_data`. The same word is folded into MISR_W. The address increments each cycle. After address N-1, move to READ with the address wrapped to 0.
- READ: `mem_req`=1, `mem_we`=0, one address per cycle. A registered "read pending" flag folds `mem_rdata` into MISR_R one cycle later. After address N-1, move to DRAIN.
- DRAIN: no request; the final read word is folded into MISR_R.
- CMP: `pass` is set to 1 if `sig_w`==`sig_r`; `busy` is still high.
- DONE: `done`=1 for one cycle and `busy`=0; return to IDLE.
- MISR step, with polynomial x^16+x^14+x^13+x^11+1:
  - fb = m[15]^m[13]^m[12]^m[10]
  - m_next = {m[14:0], fb} ^ d
- `start` outside IDLE is ignored and has no side effects.
- Reset values: state IDLE, address 0, both MISRs 16'h0000, read-pending 0. All outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `pass`, `sig_w`, `sig_r`. `mem_wdata` is forced to 0 whenever `mem_we`=0.
- Reset mid-operation aborts immediately to the reset values above. SRAM contents are undefined afterwards; a new `start` performs a full test.

## Timing
- `start` is sampled at edge 0. WRITE covers edges 1..N and READ covers edges N+1..2N. DRAIN is at 2N+1, CMP at 2N+2, and DONE (`done`=1) at 2N+3.
- Total: 2N+3 cycles from the `start` edge to the `done` pulse; N=64 gives 131.
- `pass`, `sig_w` and `sig_r` are stable from the CMP cycle until the next accepted `start`.
- A new `start` is accepted in the cycle after `done`, i.e. back-to-back tests are allowed.
- The address counter is ADDR_W bits wide and wraps naturally. The terminal condition is address == N-1 together with the state, never an overflow bit.

## Structure
- `bist_pkg`: state enum, MISR tap constants (bits 15, 13, 12, 10), MISR reset value.
- Sub-module `misr_16b` (ports: clk, rstn, clr, en, d[15:0], sig[15:0]), instantiated twice as MISR_W and MISR_R.
- The top-level module contains the FSM, address counter, read-pending flag and compare logic.

## Test plan
- Fault-free 1-cycle-latency SRAM model, N=64, real `LFSR_16B` → `done` at cycle 131, `pass`=1, `sig_w`==`sig_r`.
- SRAM with bit 3 stuck-at-1 at address 5 (written value has bit 3 = 0) → `pass`=0, `sig_w`≠`sig_r`, `done` still at cycle 131.
- ADDR_W=1, `lfsr_data` forced to 16'h0001, fault-free SRAM → `sig_w`=`sig_r`=16'h0003, `pass`=1, `done` at cycle 7.
- `start` re-pulsed during READ → ignored; single `done` pulse at the original cycle; result unchanged.
- `rstn` asserted during WRITE at address 10 → all outputs 0 and state IDLE within the same cycle. A fresh `start` after reset completes with `pass`=1.
- Two back-to-back tests, the second `start` in the cycle after `done` → both `done` pulses present, 2N+3 cycles apart plus 1; `pass` cleared between them.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the PRBS memory BIST engine.
// Holds the FSM encoding and the MISR polynomial taps.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_t;

    // Feedback taps at bits 15, 13, 12, 10 (x^16+x^14+x^13+x^11+1)
    localparam logic [15:0] MISR_TAPS = 16'hB400;
    localparam logic [15:0] MISR_RST  = 16'h0000;

    function automatic logic [15:0] misr_step(
        input logic [15:0] m,
        input logic [15:0] d
    );
        return {m[14:0], ^(m & MISR_TAPS)} ^ d;
    endfunction

endpackage

// File: rtl/misr_16b.sv
// 16-bit multiple-input signature register.
// clr wins over en; both act on the rising clock edge.
module misr_16b (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] sig
);
    import bist_pkg::*;

    // Signature register: clear, fold one word, or hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sig <= MISR_RST;
        end else if (clr) begin
            sig <= MISR_RST;
        end else if (en) begin
            sig <= misr_step(sig, d);
        end
    end

endmodule

// File: rtl/prbs_mem_bist.sv
// PRBS-driven SRAM BIST: write sweep, read sweep, then
// compare the write and read signatures.
module prbs_mem_bist #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] lfsr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       sig_w,
    output logic [15:0]       sig_r
);
    import bist_pkg::*;

    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              rd_pend;
    logic              clr;

    assign clr       = (state == S_IDLE) && start;
    assign mem_addr  = addr;
    assign mem_wdata = mem_we ? lfsr_data : '0;

    misr_16b u_misr_w (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .en   (state == S_WRITE),
        .d    (lfsr_data),
        .sig  (sig_w)
    );

    misr_16b u_misr_r (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .en   (rd_pend),
        .d    (mem_rdata),
        .sig  (sig_r)
    );

    // Sequencer: state, address sweep, read-pending and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            addr    <= '0;
            rd_pend <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            rd_pend <= (state == S_READ);
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_WRITE;
                        addr    <= '0;
                        pass    <= 1'b0;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    addr <= addr + 1'b1;
                    if (addr == LAST) begin
                        state  <= S_READ;
                        mem_we <= 1'b0;
                    end
                end
                S_READ: begin
                    addr <= addr + 1'b1;
                    if (addr == LAST) begin
                        state   <= S_DRAIN;
                        mem_req <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    state <= S_DONE;
                    pass  <= (sig_w == sig_r);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_mem_bist.sv
// Bench for prbs_mem_bist: random LFSR stream, SRAM model,
// signature reference model and timing checks.
module tb_prbs_mem_bist;

    localparam int N = 64;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [15:0] lfsr_data;
    logic        mem_req;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig_w;
    logic [15:0] sig_r;

    logic        s_start;
    logic        s_req;
    logic        s_we;
    logic [0:0]  s_addr;
    logic [15:0] s_wdata;
    logic [15:0] s_rdata;
    logic        s_busy;
    logic        s_done;
    logic        s_pass;
    logic [15:0] s_sig_w;
    logic [15:0] s_sig_r;
    logic [15:0] s_lfsr;

    logic [15:0] lfsr_q = 16'h0;
    logic [15:0] seed;
    logic        force3;
    logic        fault;
    logic [15:0] sram [64];
    logic [15:0] s_sram [2];

    int n_chk;
    int n_pass;

    prbs_mem_bist #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .lfsr_data (lfsr_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .sig_w     (sig_w),
        .sig_r     (sig_r)
    );

    prbs_mem_bist #(.ADDR_W(1), .DATA_W(16)) dut_s (
        .clk       (clk),
        .rstn      (rstn),
        .start     (s_start),
        .lfsr_data (s_lfsr),
        .mem_req   (s_req),
        .mem_we    (s_we),
        .mem_addr  (s_addr),
        .mem_wdata (s_wdata),
        .mem_rdata (s_rdata),
        .busy      (s_busy),
        .done      (s_done),
        .pass      (s_pass),
        .sig_w     (s_sig_w),
        .sig_r     (s_sig_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign lfsr_data = lfsr_q & ~{12'h0, force3, 3'b0};
    assign s_lfsr    = 16'h0001;

    always @(posedge clk)
        lfsr_q <= (lfsr_q == 16'h0) ? seed :
                  {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};

    always @(posedge clk)
        if (mem_req) begin
            if (mem_we)
                sram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= sram[mem_addr] |
                    ((fault && mem_addr == 6'd5) ? 16'h0008 : 16'h0000);
        end

    always @(posedge clk)
        if (s_req) begin
            if (s_we)
                s_sram[s_addr] <= s_wdata;
            else
                s_rdata <= s_sram[s_addr];
        end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] fold(input logic [15:0] m,
                                         input logic [15:0] d);
        logic fb;
        fb = m[15] ^ m[13] ^ m[12] ^ m[10];
        return ((m << 1) | 16'(fb)) ^ d;
    endfunction

    task automatic run_test(input bit fault_i, input bit repulse);
        logic [15:0] wq[$];
        logic [15:0] ew;
        logic [15:0] er;
        logic [15:0] rv;
        int dcyc;
        dcyc  = -1;
        fault = fault_i;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * N + 10; k++) begin
            @(negedge clk);
            start  = repulse && (k == N + 5);
            force3 = fault_i && (k == 6);
            #1;
            if (k == 1) begin
                chk("pass_clr", pass, 0);
                chk("busy_wr", busy, 1);
                chk("we_wr", {mem_req, mem_we, mem_addr}, {2'b11, 6'd0});
            end
            if (k == 3) chk("wdata_wr", mem_wdata, lfsr_data);
            if (k == N + 3) chk("wdata_rd", {mem_we, mem_wdata}, 0);
            if (k <= N) wq.push_back(lfsr_data);
            if (done) begin
                dcyc = k;
                break;
            end
        end
        start  = 1'b0;
        force3 = 1'b0;
        ew = 16'h0;
        er = 16'h0;
        for (int i = 0; i < wq.size(); i++) begin
            rv = wq[i];
            if (fault_i && i == 5) rv = rv | 16'h0008;
            ew = fold(ew, wq[i]);
            er = fold(er, rv);
        end
        chk("done_cyc", dcyc, 2 * N + 3);
        chk("sig_w", sig_w, ew);
        chk("sig_r", sig_r, er);
        chk("pass", pass, (ew == er) ? 1 : 0);
        chk("sig_diff", (sig_w != sig_r) ? 1 : 0, fault_i ? 1 : 0);
        chk("busy_done", busy, 0);
    endtask

    initial begin
        int dc;
        n_chk   = 0;
        n_pass  = 0;
        seed    = 16'($urandom_range(1, 65535));
        rstn    = 1'b0;
        start   = 1'b0;
        s_start = 1'b0;
        force3  = 1'b0;
        fault   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {mem_req, mem_we, mem_addr, mem_wdata, busy,
                         done, pass, sig_w, sig_r}, 0);
        chk("rst_outs_s", {s_req, s_we, s_addr, s_busy, s_done,
                           s_pass, s_sig_w, s_sig_r}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_test(0, 0);
        run_test(1, 0);
        run_test(0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_2nd_done", done, 0);
        end

        run_test(0, 0);
        run_test(0, 0);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("addr_pre_rst", mem_addr, 10);
        rstn = 1'b0;
        #1;
        chk("rst_mid", {mem_req, mem_we, mem_addr, mem_wdata, busy,
                        done, pass, sig_w, sig_r}, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {busy, mem_req, done}, 0);
        run_test(0, 0);

        dc = -1;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            s_start = 1'b0;
            #1;
            if (s_done) begin
                dc = k;
                break;
            end
        end
        chk("s_done_cyc", dc, 7);
        chk("s_sig_w", s_sig_w, 16'h0003);
        chk("s_sig_r", s_sig_r, 16'h0003);
        chk("s_pass", s_pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
